serial_pattern_tx: RTL and testbench
====================================

// Module: serial_pattern_tx
// PURPOSE
//   Serial bit-pattern transmitter: the driving end of the 1-bit serial input "x" consumed by the sequence detectors.
//   Captures a WIDTH-bit pattern on start and shifts it out MSB-first, one bit per clock.
//   Transmits the pattern repeat_cnt times back-to-back, then pulses done.
//   Moore-style: every output is a function of registered state only. Used as the stimulus source for detector loopback benches.
// PARAMETERS
//   WIDTH     8  pattern length in bits (>=2)
//   REPEAT_W  4  width of repeat_cnt; max transmissions = 2^REPEAT_W-1
// PORTS
//   clk         in   1         rising-edge clock
//   reset       in   1         synchronous, active-high reset
//   start       in   1         request transmission; sampled only in IDLE
//   pattern     in   WIDTH     bits to send, MSB first; captured on accepted start
//   repeat_cnt  in   REPEAT_W  number of transmissions; captured on accepted start
//   x           out  1         serial data bit (registered)
//   x_valid     out  1         high while x carries a pattern bit
//   busy        out  1         high in LOAD, SHIFT and DONE
//   done        out  1         one-cycle pulse after the final bit
//   present     out  2         current state register
//   next        out  2         combinational next-state
// BEHAVIOUR
//   States: IDLE=2'b00, LOAD=2'b01, SHIFT=2'b10, DONE=2'b11.
//   Reset (synchronous; reset wins over every other input):
//     - State goes to IDLE. The shift register, bit counter and rep counter clear to 0.
//     - x, x_valid, busy and done all clear to 0.
//   IDLE:
//     - start=1 and repeat_cnt!=0: capture pattern and repeat_cnt, next=LOAD.
//     - start=1 and repeat_cnt==0: ignored; stay in IDLE, no done.
//   LOAD (1 cycle):
//     - Load shreg<=captured pattern, bitcnt<=WIDTH-1, repcnt<=captured count. x_valid=0.
//     - next=SHIFT.
//   SHIFT:
//     - x=shreg[WIDTH-1], x_valid=1. Each cycle shreg shifts left by 1 and bitcnt decrements.
//     - At bitcnt==0 with repcnt>1: reload shreg from the captured pattern, bitcnt<=WIDTH-1, repcnt-1.
//       Stay in SHIFT with no idle gap between repetitions.
//     - At bitcnt==0 with repcnt==1: next=DONE.
//   DONE (1 cycle):
//     - done=1, x_valid=0, x=0. next=IDLE.
//   Latency:
//     - start sampled at edge k -> LOAD in cycle k+1 -> first bit valid in cycle k+2.
//     - Last bit valid in cycle k+1+WIDTH*repeat_cnt; done in the following cycle.
//   Bus and input rules:
//     - When x_valid=0, x is 0.
//     - Changes to pattern or repeat_cnt after capture have no effect.
//     - start is ignored while busy; there is no queueing.
//     - start asserted in the DONE cycle is ignored. It is accepted on the next IDLE cycle if still high.
//   Width rules:
//     - bitcnt is $clog2(WIDTH) bits; repcnt is REPEAT_W bits.
//     - Counters never wrap: the exit conditions are checked before decrement.
//   Reset mid-operation: the transmission aborts with no done pulse, and the next start is accepted normally.
// TESTING
//   1. reset 2 cycles; start=1 for 1 cycle, pattern=8'hA5, repeat_cnt=1
//      -> x=1,0,1,0,0,1,0,1 with x_valid=1 in cycles k+2..k+9; done=1 in cycle k+10 only.
//   2. pattern=8'h05, repeat_cnt=3
//      -> x_valid high for 24 consecutive cycles; x = 00000101 three times; exactly one done pulse.
//   3. start pulsed and pattern changed to 8'hFF during SHIFT
//      -> transmitted bits unchanged; no extra transmission; present never leaves SHIFT early.
//   4. start=1 with repeat_cnt=0
//      -> present stays 2'b00, busy=0, no done.
//   5. reset asserted during the 4th bit
//      -> next cycle present=00, x=0, x_valid=0, no done; a subsequent start sends the full pattern.
//   6. Loopback: x into the 101 Moore detector, clocked only when x_valid=1, pattern=8'b10101000
//      -> detector out asserts twice (overlapping matches).

Source files
------------

// File: rtl/serial_pattern_tx_if.sv
// Request and serial-stream bundle for serial_pattern_tx.
// The slave side is the transmitter; the master side is the requester/observer.
interface serial_pattern_tx_if #(
    parameter int WIDTH    = 8,
    parameter int REPEAT_W = 4
);
    logic                start;
    logic [WIDTH-1:0]    pattern;
    logic [REPEAT_W-1:0] repeat_cnt;
    logic                x;
    logic                x_valid;
    logic                busy;
    logic                done;
    logic [1:0]          present;
    logic [1:0]          next;

    modport master (
        output start, pattern, repeat_cnt,
        input  x, x_valid, busy, done, present, next
    );

    modport slave (
        input  start, pattern, repeat_cnt,
        output x, x_valid, busy, done, present, next
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first,
// repeat_cnt times back-to-back, then pulses done for one cycle.
module serial_pattern_tx #(
    parameter int WIDTH    = 8,
    parameter int REPEAT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    serial_pattern_tx_if.slave bus
);
    localparam int BW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    pat_q, pat_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic [REPEAT_W-1:0] rep_q, rep_d;
    logic [REPEAT_W-1:0] repcnt_q, repcnt_d;
    logic [BW-1:0]       bitcnt_q, bitcnt_d;
    logic                x_q, x_d;
    logic                xv_q, xv_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                accept;
    logic                last_bit;
    logic                more;

    assign accept   = bus.start && (bus.repeat_cnt != '0);
    assign last_bit = (bitcnt_q == '0);
    assign more     = (repcnt_q > REPEAT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pat_q    <= '0;
            rep_q    <= '0;
            shreg_q  <= '0;
            repcnt_q <= '0;
            bitcnt_q <= '0;
            x_q      <= 1'b0;
            xv_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            rep_q    <= rep_d;
            shreg_q  <= shreg_d;
            repcnt_q <= repcnt_d;
            bitcnt_q <= bitcnt_d;
            x_q      <= x_d;
            xv_q     <= xv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Exit checks look at the counters before they decrement, so nothing wraps.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        rep_d    = rep_q;
        shreg_d  = shreg_q;
        repcnt_d = repcnt_q;
        bitcnt_d = bitcnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    pat_d   = bus.pattern;
                    rep_d   = bus.repeat_cnt;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shreg_d  = pat_q;
                bitcnt_d = BW'(WIDTH - 1);
                repcnt_d = rep_q;
                state_d  = SHIFT;
            end
            SHIFT: begin
                if (!last_bit) begin
                    shreg_d  = shreg_q << 1;
                    bitcnt_d = bitcnt_q - BW'(1);
                end else if (more) begin
                    shreg_d  = pat_q;
                    bitcnt_d = BW'(WIDTH - 1);
                    repcnt_d = repcnt_q - REPEAT_W'(1);
                end else begin
                    shreg_d = shreg_q << 1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
        if (reset) begin
            state_d = IDLE;
        end
    end

    // Outputs are registered copies of what the next state will present.
    always_comb begin
        xv_d   = (state_d == SHIFT);
        x_d    = xv_d & shreg_d[WIDTH-1];
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign bus.x       = x_q;
    assign bus.x_valid = xv_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.present = state_q;
    assign bus.next    = state_d;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: expected bit/done events with
// cycle stamps are queued at issue time and consumed by a negedge monitor.
module tb_serial_pattern_tx;
    typedef struct {
        int   cyc;
        logic b;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;
    ev_t  bitq[$];
    int   doneq[$];
    int   busy_lo = 1;
    int   busy_hi = 0;
    int   det = 0;
    int   hits = 0;

    serial_pattern_tx_if #(.WIDTH(8), .REPEAT_W(4)) bus ();

    serial_pattern_tx #(.WIDTH(8), .REPEAT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: bit i of a transmission issued in cycle c appears in cycle c+2+i.
    task automatic send(input logic [7:0] p, input logic [3:0] r, input bit noise_ff);
        int c;
        int dc;
        c = cyc;
        bus.start      = 1'b1;
        bus.pattern    = p;
        bus.repeat_cnt = r;
        dc = c;
        if (r != 0) begin
            for (int i = 0; i < 8 * int'(r); i++) begin
                ev_t e;
                e.cyc = c + 2 + i;
                e.b   = p[7 - (i % 8)];
                bitq.push_back(e);
            end
            dc = c + 2 + 8 * int'(r);
            doneq.push_back(dc);
            busy_lo = c + 1;
            busy_hi = dc;
        end
        step();
        if (r == 0) begin
            chk("zero_rep_present", int'(bus.present), 0);
            chk("zero_rep_busy", int'(bus.busy), 0);
        end
        while (cyc <= dc) begin
            bus.start      = noise_ff ? 1'b1 : 1'($urandom);
            bus.pattern    = noise_ff ? 8'hFF : 8'($urandom);
            bus.repeat_cnt = 4'($urandom);
            step();
        end
        bus.start = 1'b0;
    endtask

    task automatic reset_mid(input logic [7:0] p);
        int c;
        int r;
        c = cyc;
        bus.start      = 1'b1;
        bus.pattern    = p;
        bus.repeat_cnt = 4'd1;
        for (int i = 0; i < 8; i++) begin
            ev_t e;
            e.cyc = c + 2 + i;
            e.b   = p[7 - i];
            bitq.push_back(e);
        end
        busy_lo = c + 1;
        busy_hi = c + 10;
        step();
        bus.start = 1'b0;
        while (cyc < c + 5) step();
        r = cyc;
        reset = 1'b1;
        while (bitq.size() != 0 && bitq[$].cyc > r) void'(bitq.pop_back());
        busy_hi = r;
        step();
        reset = 1'b0;
        chk("rst_mid_present", int'(bus.present), 0);
        chk("rst_mid_x", int'(bus.x), 0);
        chk("rst_mid_x_valid", int'(bus.x_valid), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (bitq.size() != 0 && bitq[0].cyc < cyc) begin
                chk("bit_missed", bitq[0].cyc, cyc);
                void'(bitq.pop_front());
            end
            while (doneq.size() != 0 && doneq[0] < cyc) begin
                chk("done_missed", doneq[0], cyc);
                void'(doneq.pop_front());
            end
            if (bus.x_valid) begin
                if (bitq.size() == 0) begin
                    chk("x_valid_unexpected", 1, 0);
                end else begin
                    ev_t e;
                    e = bitq.pop_front();
                    chk("bit_cycle", cyc, e.cyc);
                    chk("bit_value", int'(bus.x), int'(e.b));
                end
                // 101 Moore detector fed only by valid bits
                if (det == 2 && bus.x) hits++;
                case (det)
                    0: det = bus.x ? 1 : 0;
                    1: det = bus.x ? 1 : 2;
                    2: det = bus.x ? 3 : 0;
                    default: det = bus.x ? 1 : 2;
                endcase
            end else begin
                chk("x_idle_zero", int'(bus.x), 0);
            end
            if (bus.done) begin
                if (doneq.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_cycle", cyc, doneq.pop_front());
            end
            chk("busy", int'(bus.busy), int'(cyc >= busy_lo && cyc <= busy_hi));
        end
    end

    initial begin
        bus.start      = 1'b0;
        bus.pattern    = '0;
        bus.repeat_cnt = '0;
        reset          = 1'b1;
        repeat (2) step();
        chk("rst_present", int'(bus.present), 0);
        chk("rst_next", int'(bus.next), 0);
        chk("rst_x", int'(bus.x), 0);
        chk("rst_x_valid", int'(bus.x_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        step();

        send(8'hA5, 4'd1, 1'b0);
        send(8'h05, 4'd3, 1'b0);
        send(8'hA5, 4'd2, 1'b1);
        send(8'h3C, 4'd0, 1'b0);
        step();
        reset_mid(8'hC3);
        send(8'hC3, 4'd1, 1'b0);

        det  = 0;
        hits = 0;
        send(8'b10101000, 4'd1, 1'b0);
        chk("loopback_101_hits", hits, 2);

        for (int t = 0; t < 25; t++) begin
            send(8'($urandom), 4'($urandom_range(0, 3)), 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end
        send(8'h81, 4'd15, 1'b0);

        repeat (3) step();
        chk("queues_drained", bitq.size() + doneq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
